pump_valve_sequencer: RTL and testbench



---
 rtl/pump_valve_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pump_valve_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pump_valve_sequencer.sv
// pump_valve_sequencer
//   Generates the control-air pattern for an N-stage peristaltic pump, the
//   outlet valve that gates the pump into the serpentine, and the serpentine
//   dwell timing. Firmware issues one start per dose and waits for done.
//   Abort returns every air line to the safe, pressurized state.
//
// Handshake: start is a single-cycle request that is taken only while the
//   sequencer is idle (busy = 0 and not in the done/abort cycle). A start
//   seen at any other time is dropped. Completion is reported by a
//   one-cycle done pulse. An abort is reported by a one-cycle aborted pulse.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   start         request a dose (taken only in IDLE)
//   abort         cancel the dose in progress (no effect in IDLE or DONE)
//   dir           0 = forward (stage 0..N-1), 1 = reverse; latched at accept
//   stroke_count  pump strokes for this dose; latched at accept
//   step_period   cycles per phase (0 behaves as 1); latched at accept
//   dwell         serpentine dwell cycles (0 skips the dwell); latched
//   pump_valve    per-stage air line, 1 = pressurized (membrane closed)
//   outlet_valve  1 = outlet closed
//   busy          high from accept until done
//   done          one-cycle pulse at normal completion
//   aborted       one-cycle pulse when an abort takes effect
//   strokes_done  completed strokes in the current or last dose
//   state_dbg     current FSM state encoding, for observation only
module pump_valve_sequencer #(
    parameter int NUM_VALVES = 3,
    parameter int PER_W      = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dir,
    input  logic [CNT_W-1:0]      stroke_count,
    input  logic [PER_W-1:0]      step_period,
    input  logic [PER_W-1:0]      dwell,
    output logic [NUM_VALVES-1:0] pump_valve,
    output logic                  outlet_valve,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [CNT_W-1:0]      strokes_done,
    output logic [2:0]            state_dbg
);

    localparam int PH_W = $clog2(NUM_VALVES);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_VALVES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPEN_OUT  = 3'd1,
        S_PUMP      = 3'd2,
        S_CLOSE_OUT = 3'd3,
        S_DWELL     = 3'd4,
        S_DONE      = 3'd5,
        S_ABORTED   = 3'd6
    } state_t;

    state_t            state;
    logic              dir_q;
    logic [CNT_W-1:0]  stroke_q;
    logic [PER_W-1:0]  per_q;
    logic [PER_W-1:0]  dwell_q;
    logic [PER_W-1:0]  tmr;      // counts down; a phase ends when it reaches 0
    logic [PH_W-1:0]   phase;
    logic [PER_W-1:0]  eff_per;
    logic [CNT_W-1:0]  strokes_inc;

    assign state_dbg = state;

    // Air pattern for one pump phase: exactly one stage released.
    function automatic logic [NUM_VALVES-1:0] stage_mask(input logic [PH_W-1:0] ph,
                                                         input logic rev);
        logic [NUM_VALVES-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_VALVES; i++) begin
            if ((rev ? (NUM_VALVES - 1 - i) : i) == int'(ph)) m[i] = 1'b0;
        end
        return m;
    endfunction

    always_comb begin
        eff_per     = (step_period == '0) ? PER_W'(1) : step_period;
        strokes_inc = (strokes_done == '1) ? strokes_done : strokes_done + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pump_valve   <= '1;
            outlet_valve <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            strokes_done <= '0;
            dir_q        <= 1'b0;
            stroke_q     <= '0;
            per_q        <= PER_W'(1);
            dwell_q      <= '0;
            tmr          <= '0;
            phase        <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    dir_q        <= dir;
                    stroke_q     <= stroke_count;
                    per_q        <= eff_per;
                    dwell_q      <= dwell;
                    strokes_done <= '0;
                    phase        <= '0;
                    if (stroke_count == '0) begin
                        // Nothing to pump: report completion without moving a valve.
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= S_OPEN_OUT;
                        busy         <= 1'b1;
                        outlet_valve <= 1'b0;
                        tmr          <= eff_per - PER_W'(1);
                    end
                end
            end else if (abort && state != S_DONE && state != S_ABORTED) begin
                // Done already issued in S_DONE, so abort is only honoured before it.
                state        <= S_ABORTED;
                aborted      <= 1'b1;
                busy         <= 1'b0;
                pump_valve   <= '1;
                outlet_valve <= 1'b1;
            end else begin
                case (state)
                    S_OPEN_OUT: begin
                        if (tmr == '0) begin
                            state      <= S_PUMP;
                            phase      <= '0;
                            tmr        <= per_q - PER_W'(1);
                            pump_valve <= stage_mask(PH_W'(0), dir_q);
                        end else begin
                            tmr <= tmr - PER_W'(1);
                        end
                    end
                    S_PUMP: begin
                        if (tmr != '0) begin
                            tmr <= tmr - PER_W'(1);
                        end else begin
                            tmr <= per_q - PER_W'(1);
                            if (phase != LAST_PH) begin
                                phase      <= phase + PH_W'(1);
                                pump_valve <= stage_mask(phase + PH_W'(1), dir_q);
                            end else begin
                                // End of a stroke: the count is visible from the next cycle.
                                strokes_done <= strokes_inc;
                                phase        <= '0;
                                if (strokes_inc == stroke_q) begin
                                    state        <= S_CLOSE_OUT;
                                    pump_valve   <= '1;
                                    outlet_valve <= 1'b1;
                                end else begin
                                    pump_valve <= stage_mask(PH_W'(0), dir_q);
                                end
                            end
                        end
                    end
                    S_CLOSE_OUT: begin
                        if (tmr != '0) begin
                            tmr <= tmr - PER_W'(1);
                        end else if (dwell_q == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DWELL;
                            tmr   <= dwell_q - PER_W'(1);
                        end
                    end
                    S_DWELL: begin
                        if (tmr != '0) begin
                            tmr <= tmr - PER_W'(1);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        // S_DONE and S_ABORTED last one cycle before IDLE.
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pump_valve_sequencer.sv
// Bench for pump_valve_sequencer: directed doses, a timeline model of the
// expected outputs, and a per-cycle compare against that model.
module tb_pump_valve_sequencer;

    localparam int N  = 3;
    localparam int PW = 16;
    localparam int CW = 8;
    localparam int W  = N + 4 + CW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          dir;
    logic [CW-1:0] stroke_count;
    logic [PW-1:0] step_period;
    logic [PW-1:0] dwell;
    logic [N-1:0]  pump_valve;
    logic          outlet_valve;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] strokes_done;
    logic [2:0]    state_dbg;

    pump_valve_sequencer #(.NUM_VALVES(N), .PER_W(PW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .dir          (dir),
        .stroke_count (stroke_count),
        .step_period  (step_period),
        .dwell        (dwell),
        .pump_valve   (pump_valve),
        .outlet_valve (outlet_valve),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .strokes_done (strokes_done),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- model ----------------
    // The dose is described as a timeline: cycle c after the accepting edge.
    // mode 0 = idle, 1 = dose running, 2 = the single abort-report cycle.
    logic [W-1:0] exp_q[$];
    int           m_mode = 0;
    int           m_c, m_L, m_s, m_p, m_d, idx, k, stage;
    logic         m_dir;
    logic         model_live = 1'b0;
    logic [N-1:0] e_pump;
    logic         e_out, e_busy, e_done, e_abt;
    int           e_str = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0;
            e_pump = '1; e_out = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_abt = 1'b0;
            e_str = 0;
            model_live = 1'b1;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_dir = dir;
                    m_s   = int'(stroke_count);
                    m_p   = (step_period == 0) ? 1 : int'(step_period);
                    m_d   = int'(dwell);
                    m_c   = 1;
                    m_L   = (m_s == 0) ? 1 : 2 * m_p + m_s * N * m_p + m_d + 1;
                    m_mode = 1;
                end
                1: begin
                    if (m_c == m_L) m_mode = 0;
                    else if (abort) m_mode = 2;
                    else m_c = m_c + 1;
                end
                default: m_mode = 0;
            endcase
            e_pump = '1; e_out = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_abt = 1'b0;
            if (m_mode == 2) begin
                e_abt = 1'b1;          // strokes_done keeps the value already shown
            end else if (m_mode == 1) begin
                if (m_c == m_L) begin
                    e_done = 1'b1;
                    e_str  = m_s;
                end else begin
                    e_busy = 1'b1;
                    if (m_c <= m_p) begin
                        e_out = 1'b0;
                        e_str = 0;
                    end else if (m_c <= m_p + m_s * N * m_p) begin
                        e_out = 1'b0;
                        idx   = m_c - m_p - 1;
                        k     = (idx % (N * m_p)) / m_p;
                        stage = m_dir ? (N - 1 - k) : k;
                        e_pump[stage] = 1'b0;
                        e_str = idx / (N * m_p);
                    end else begin
                        e_str = m_s;
                    end
                end
            end
        end
        if (model_live)
            exp_q.push_back({e_pump, e_out, e_busy, e_done, e_abt, CW'(e_str)});
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_v, got_v;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {pump_valve, outlet_valve, busy, done, aborted, strokes_done};
            n_vec++;
            if (got_v !== exp_v) begin
                n_miss++;
                $display("FAIL model_cycle t=%0t got pump/out/busy/done/abt/strokes=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                         $time, got_v[W-1 -: N], got_v[CW+3], got_v[CW+2], got_v[CW+1], got_v[CW],
                         got_v[CW-1:0], exp_v[W-1 -: N], exp_v[CW+3], exp_v[CW+2], exp_v[CW+1],
                         exp_v[CW], exp_v[CW-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int got, input int expv);
        n_vec++;
        if (got != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a start for exactly one edge; returns one unit after the accepting edge.
    task automatic start_dose(input logic d, input int s, input int p, input int dw);
        dir          = d;
        stroke_count = CW'(s);
        step_period  = PW'(p);
        dwell        = PW'(dw);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int bound);
        int lat;
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check(name, lat, exp_lat);
        tick();
    endtask

    // ---------------- stimulus ----------------
    int dcnt, dcyc;
    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0;
        stroke_count = '0; step_period = '0; dwell = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_pump", int'(pump_valve), 7);
        check("reset_outlet", int'(outlet_valve), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_strokes", int'(strokes_done), 0);
        tick();

        // Nominal forward: P=4, S=2, D=5, done in cycle 38.
        start_dose(1'b0, 2, 4, 5);
        for (int i = 1; i <= 38; i++) begin
            @(negedge clk);
            if (i == 1)  check("fwd_busy_c1", int'(busy), 1);
            if (i == 5)  check("fwd_pump_c5", int'(pump_valve), 6);
            if (i == 9)  check("fwd_pump_c9", int'(pump_valve), 5);
            if (i == 13) check("fwd_pump_c13", int'(pump_valve), 3);
            if (i == 17) check("fwd_pump_c17", int'(pump_valve), 6);
            if (i == 28) check("fwd_outlet_c28", int'(outlet_valve), 0);
            if (i == 29) check("fwd_outlet_c29", int'(outlet_valve), 1);
            if (i == 37) check("fwd_nodone_c37", int'(done), 0);
            if (i == 38) check("fwd_done_c38", int'(done), 1);
            if (i == 38) check("fwd_strokes", int'(strokes_done), 2);
        end
        tick();

        // Reverse, P=0 behaves as 1, S=1, D=0: done in cycle 6.
        start_dose(1'b1, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 2) check("rev_pump_c2", int'(pump_valve), 3);
            if (i == 3) check("rev_pump_c3", int'(pump_valve), 5);
            if (i == 4) check("rev_pump_c4", int'(pump_valve), 6);
            if (i == 5) check("rev_outlet_c5", int'(outlet_valve), 1);
            if (i == 6) check("rev_done_c6", int'(done), 1);
        end
        tick();

        // Abort during stroke 2 phase 1 (cycles 21..24), sampled at edge 22.
        start_dose(1'b0, 2, 4, 3);
        repeat (21) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abt_pulse", int'(aborted), 1);
        check("abt_busy", int'(busy), 0);
        check("abt_pump", int'(pump_valve), 7);
        check("abt_outlet", int'(outlet_valve), 1);
        check("abt_strokes", int'(strokes_done), 1);
        tick();
        start_dose(1'b0, 1, 1, 0);
        wait_done("abt_restart_lat", 6, 20);

        // stroke_count = 0: done in cycle 1, busy never asserts.
        start_dose(1'b0, 0, 3, 3);
        @(negedge clk);
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_pump", int'(pump_valve), 7);
        tick();

        // start pulsed mid-dose is ignored: P=2, S=3, D=1 -> L = 24.
        start_dose(1'b0, 3, 2, 1);
        dcnt = 0; dcyc = -1;
        for (int i = 1; i <= 30; i++) begin
            start = (i == 5);
            stroke_count = CW'(1);
            @(negedge clk);
            if (done) begin
                dcnt++;
                dcyc = i;
            end
            tick();
        end
        start = 1'b0;
        check("busy_start_dones", dcnt, 1);
        check("busy_start_lat", dcyc, 24);

        // abort with start in IDLE is a no-op; abort in DONE is ignored.
        abort = 1'b1;
        start_dose(1'b1, 1, 1, 2);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abt_aborted", int'(aborted), 0);
        check("idle_abt_busy", int'(busy), 1);
        repeat (7) tick();
        abort = 1'b1;
        @(negedge clk);
        check("done_abt_done", int'(done), 1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("done_abt_aborted", int'(aborted), 0);
        tick();

        // Back-to-back doses with one idle cycle in between.
        start_dose(1'b0, 1, 1, 0);
        wait_done("b2b_first", 6, 20);
        start_dose(1'b1, 1, 1, 0);
        wait_done("b2b_second", 6, 20);

        // Reset mid-dose (strokes_done is 1 by cycle 20).
        start_dose(1'b0, 2, 4, 5);
        repeat (19) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("midrst_pump", int'(pump_valve), 7);
        check("midrst_outlet", int'(outlet_valve), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_strokes", int'(strokes_done), 0);
        check("midrst_pulses", int'({done, aborted}), 0);
        rst_n = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
